// File: rtl/rr_arb8_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
package rr_arb8_pkg;

  localparam int unsigned NREQ   = 8;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned HOLD_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  // Rotate right so that bit s of v lands at position 0.
  function automatic logic [NREQ-1:0] rotr8(input logic [NREQ-1:0] v,
                                            input logic [IDX_W-1:0] s);
    logic [2*NREQ-1:0] w;
    w = {v, v} >> s;
    return w[NREQ-1:0];
  endfunction

endpackage

// File: rtl/rr_arb8_prio_enc8.sv
// 8-input priority encoder: lowest set bit wins, any_o flags a hit.
module prio_enc8
  import rr_arb8_pkg::*;
(
  input  logic [NREQ-1:0]  in_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (in_i[i]) begin
        idx_o = IDX_W'(i);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arb8_ctrl.sv
// Round-robin arbiter for 8 requesters with hold-time limit and one-cycle
// release gap between owners. All outputs are registered.
module rr_arb8_ctrl
  import rr_arb8_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic             done,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                vld_q, vld_d;
  logic                to_q, to_d;

  logic [NREQ-1:0]     req_rot;
  logic [IDX_W-1:0]    enc_idx, win_idx;
  logic                enc_any;
  logic                owner_req, at_limit;

  // Search starts at ptr: rotate down, encode, rotate the index back up.
  assign req_rot = rotr8(req, ptr_q);

  prio_enc8 u_enc (
    .in_i  (req_rot),
    .idx_o (enc_idx),
    .any_o (enc_any)
  );

  assign win_idx   = enc_idx + ptr_q;
  assign owner_req = req[idx_q];
  // hold_q counts completed grant cycles, so this is the MAX_HOLD-th cycle.
  assign at_limit  = (hold_q == HOLD_LIM - 4'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      hold_q  <= '0;
      gnt_q   <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (enc_any) state_d = ST_GRANT;
      ST_GRANT:   if (done || at_limit || !owner_req) state_d = ST_RELEASE;
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt_d  = '0;
    idx_d  = idx_q;
    vld_d  = 1'b0;
    to_d   = 1'b0;
    ptr_d  = ptr_q;
    hold_d = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (enc_any) begin
          gnt_d  = NREQ'(1) << win_idx;
          idx_d  = win_idx;
          vld_d  = 1'b1;
          hold_d = '0;
        end
      end
      ST_GRANT: begin
        if (state_d == ST_GRANT) begin
          gnt_d  = gnt_q;
          vld_d  = 1'b1;
          hold_d = (hold_q == HOLD_LIM) ? hold_q : hold_q + 4'd1;
        end else begin
          // done on the limit cycle is an ordinary release.
          to_d = at_limit && !done;
        end
      end
      ST_RELEASE: ptr_d = idx_q + 3'd1;
      default: ;
    endcase
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = vld_q;
  assign timeout   = to_q;

endmodule

// File: tb/tb_rr_arb8_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against a
// transaction-level model of owner, hold time and round-robin pointer.
module tb_rr_arb8_ctrl;

  localparam int MH = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = '0;
  logic       done = 1'b0;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int n_chk = 0;
  int n_fail = 0;

  // model state
  int   m_owner = -1;
  int   m_held = 0;
  int   m_ptr = 0;
  int   m_idx = 0;
  bit   m_rel = 0;
  bit   m_to = 0;
  logic [7:0] exp_gnt;

  rr_arb8_ctrl #(.MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic [7:0] rq, input logic dn);
    bit found;
    int j;
    m_to = 0;
    if (r) begin
      m_owner = -1; m_ptr = 0; m_held = 0; m_rel = 0; m_idx = 0;
    end else if (m_rel) begin
      m_rel = 0;
      m_ptr = (m_idx + 1) % 8;
    end else if (m_owner < 0) begin
      found = 0;
      for (int k = 0; k < 8; k++) begin
        j = (m_ptr + k) % 8;
        if (!found && rq[j]) begin
          found = 1; m_owner = j; m_idx = j; m_held = 1;
        end
      end
    end else if (dn) begin
      m_owner = -1; m_rel = 1;
    end else if (m_held == MH) begin
      m_owner = -1; m_rel = 1; m_to = 1;
    end else if (!rq[m_owner]) begin
      m_owner = -1; m_rel = 1;
    end else begin
      m_held++;
    end
  endtask

  task automatic cyc(input logic r, input logic [7:0] rq, input logic dn);
    rst = r; req = rq; done = dn;
    @(posedge clk);
    model_step(r, rq, dn);
    #1;
    exp_gnt = '0;
    if (m_owner >= 0) exp_gnt[m_owner] = 1'b1;
    chk("gnt", gnt, exp_gnt);
    chk("gnt_valid", gnt_valid, m_owner >= 0);
    chk("gnt_idx", gnt_idx, m_idx);
    chk("timeout", timeout, m_to);
    chk("onehot", $onehot0(gnt), 1);
  endtask

  initial begin
    int cnt;
    bit seen;
    logic [7:0] rq;
    logic dn;

    // reset and idle
    cyc(1, 8'h00, 0);
    chk("rst_gnt", gnt, 8'h00);
    chk("rst_idx", gnt_idx, 3'd0);
    for (int i = 0; i < 5; i++) cyc(0, 8'h00, 0);
    chk("idle_gnt", gnt, 8'h00);

    // first grant from 0 upward, then pointer advance after release
    cyc(0, 8'h24, 0);
    chk("d31_g2", gnt, 8'h04);
    chk("d31_i2", gnt_idx, 3'd2);
    cyc(0, 8'h24, 1);
    chk("d31_rel", gnt, 8'h00);
    cyc(0, 8'h24, 0);
    chk("d31_idle", gnt, 8'h00);
    cyc(0, 8'h24, 0);
    chk("d31_g5", gnt, 8'h20);
    chk("d31_i5", gnt_idx, 3'd5);

    // fairness with everyone requesting
    cyc(1, 8'hFF, 0);
    for (int g = 0; g < 9; g++) begin
      cnt = 0;
      while (!gnt_valid && cnt < 5) begin cyc(0, 8'hFF, 0); cnt++; end
      chk("d32_wait", gnt_valid, 1);
      chk("d32_order", gnt_idx, g % 8);
      cyc(0, 8'hFF, 1);
    end

    // hold limit with a lone requester 7
    cyc(1, 8'h80, 0);
    cnt = 0; seen = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(0, 8'h80, 0);
      if (gnt == 8'h80) begin cnt++; seen = 1; end
      else if (seen) break;
    end
    chk("d33_hold", cnt, MH);
    chk("d33_to", timeout, 1);
    cyc(0, 8'h80, 0);
    chk("d33_to_off", timeout, 0);
    cyc(0, 8'h80, 0);
    chk("d33_regnt", gnt, 8'h80);

    // owner drops its request
    cyc(1, 8'h00, 0);
    cyc(0, 8'h08, 0);
    chk("d34_g3", gnt, 8'h08);
    cyc(0, 8'h00, 0);
    chk("d34_drop", gnt, 8'h00);
    chk("d34_to", timeout, 0);
    cyc(0, 8'hFF, 0);
    cyc(0, 8'hFF, 0);
    chk("d34_ptr4", gnt, 8'h10);

    // reset mid-grant
    cyc(1, 8'h00, 0);
    cyc(0, 8'h40, 0);
    chk("d35_g6", gnt, 8'h40);
    cyc(1, 8'h41, 0);
    chk("d35_rst", gnt, 8'h00);
    chk("d35_to", timeout, 0);
    cyc(0, 8'h41, 0);
    chk("d35_g0", gnt, 8'h01);

    // random traffic
    rq = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3, 0) == 0) rq = 8'($urandom);
      if ($urandom_range(7, 0) == 0) rq = 8'h00;
      dn = ($urandom_range(4, 0) == 0);
      cyc($urandom_range(199, 0) == 0, rq, dn);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
